// File: rtl/seg_cfg_if.sv
// Configuration/load bundle between the CPU data path and the scan driver.
// master drives data_in/dp_in/blink_mask/lz_en/brightness/load; slave returns load_pending.
interface seg_cfg_if #(
  parameter int DIGITS = 8,
  parameter int BR_W   = 3
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blink_mask;
  logic                load;
  logic                lz_en;
  logic [BR_W-1:0]     brightness;
  logic                load_pending;

  modport master (
    output data_in,
    output dp_in,
    output blink_mask,
    output load,
    output lz_en,
    output brightness,
    input  load_pending
  );

  modport slave (
    input  data_in,
    input  dp_in,
    input  blink_mask,
    input  load,
    input  lz_en,
    input  brightness,
    output load_pending
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed active-low 7-segment scan driver with frame-synchronous loads.
// Ports: clk, rst_n, cfg (seg_cfg_if.slave), SEG[7:0], AN[DIGITS-1:0], frame_done.
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 40000,
  parameter int BR_W         = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_cfg_if.slave          cfg,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN,
  output logic              frame_done
);

  localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW   = $clog2(DIGITS);
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int MW   = CW + BR_W;
  localparam int DW   = 4 * DIGITS;
  localparam int STEP = CLK_DIV >> BR_W;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic              frame_done_q, frame_done_d;
  logic              pend_q, pend_d;

  logic [DW-1:0]     sh_data_q, sh_data_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0] sh_bm_q, sh_bm_d;
  logic              sh_lz_q, sh_lz_d;
  logic [BR_W-1:0]   sh_br_q, sh_br_d;

  logic [DW-1:0]     lv_data_q, lv_data_d;
  logic [DIGITS-1:0] lv_dp_q, lv_dp_d;
  logic [DIGITS-1:0] lv_bm_q, lv_bm_d;
  logic              lv_lz_q, lv_lz_d;
  logic [BR_W-1:0]   lv_br_q, lv_br_d;

  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick;
  logic              wrap;
  logic [3:0]        nib;
  logic              dp_cur;
  logic              bm_cur;
  logic              zero_run;
  logic              sup_cur;
  logic              blank;
  logic              gate;
  logic [MW-1:0]     thr;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    unique case (v)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h18;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      4'hF: f = 7'h0E;
      default: f = 7'h7F;
    endcase
    return f;
  endfunction

  // prescaler, scan position, blink and load handshake
  always_comb begin
    tick         = (cnt_q == CW'(CLK_DIV - 1));
    wrap         = tick && (pos_q == PW'(DIGITS - 1));
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    pos_d        = pos_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    frame_done_d = wrap;
    if (tick) begin
      pos_d = wrap ? '0 : pos_q + PW'(1);
    end
    if (wrap) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_bm_d   = sh_bm_q;
    sh_lz_d   = sh_lz_q;
    sh_br_d   = sh_br_q;
    lv_data_d = lv_data_q;
    lv_dp_d   = lv_dp_q;
    lv_bm_d   = lv_bm_q;
    lv_lz_d   = lv_lz_q;
    lv_br_d   = lv_br_q;
    pend_d    = pend_q;

    // live takes the old shadow; a coincident load only refills shadow
    if (wrap && pend_q) begin
      lv_data_d = sh_data_q;
      lv_dp_d   = sh_dp_q;
      lv_bm_d   = sh_bm_q;
      lv_lz_d   = sh_lz_q;
      lv_br_d   = sh_br_q;
      pend_d    = 1'b0;
    end
    if (cfg.load) begin
      sh_data_d = cfg.data_in;
      sh_dp_d   = cfg.dp_in;
      sh_bm_d   = cfg.blink_mask;
      sh_lz_d   = cfg.lz_en;
      sh_br_d   = cfg.brightness;
      pend_d    = 1'b1;
    end
  end

  // digit decode, blanking and PWM gate
  always_comb begin
    nib      = 4'h0;
    dp_cur   = 1'b0;
    bm_cur   = 1'b0;
    zero_run = 1'b1;
    sup_cur  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (lv_data_q[4*i +: 4] == 4'h0);
      if (pos_q == PW'(i)) begin
        nib     = lv_data_q[4*i +: 4];
        dp_cur  = lv_dp_q[i];
        bm_cur  = lv_bm_q[i];
        sup_cur = zero_run;
      end
    end
    thr   = MW'(lv_br_q) * MW'(STEP);
    gate  = (&lv_br_q) || (MW'(cnt_q) < thr);
    blank = (lv_lz_q && (pos_q != '0) && sup_cur)
         || (bm_cur && !blink_on_q)
         || !gate;
    seg_d = 8'hFF;
    an_d  = '1;
    if (!blank) begin
      seg_d       = {~dp_cur, hex_font(nib)};
      an_d[pos_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      pos_q        <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_bm_q      <= '0;
      sh_lz_q      <= 1'b0;
      sh_br_q      <= '0;
      lv_data_q    <= '0;
      lv_dp_q      <= '0;
      lv_bm_q      <= '0;
      lv_lz_q      <= 1'b0;
      lv_br_q      <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_bm_q      <= sh_bm_d;
      sh_lz_q      <= sh_lz_d;
      sh_br_q      <= sh_br_d;
      lv_data_q    <= lv_data_d;
      lv_dp_q      <= lv_dp_d;
      lv_bm_q      <= lv_bm_d;
      lv_lz_q      <= lv_lz_d;
      lv_br_q      <= lv_br_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign SEG              = seg_q;
  assign AN               = an_q;
  assign frame_done       = frame_done_q;
  assign cfg.load_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised self-checking bench for seg_scan_display.
// Expected outputs come from a timeline model of loads, frames and slots.
module tb_seg_scan_display;

  localparam int D  = 8;
  localparam int CD = 16;
  localparam int BR = 2;
  localparam int BF = 2;
  localparam int FR = D * CD;

  typedef struct {
    int          m;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  bm;
    logic        lz;
    logic [1:0]  br;
  } cfg_t;

  logic         clk;
  logic         rst_n;
  logic [7:0]   SEG;
  logic [D-1:0] AN;
  logic         frame_done;

  int           ecnt;
  int           checks;
  int           fails;
  cfg_t         log_q[$];
  logic [17:0]  exp_v;
  logic [17:0]  got_v;

  seg_cfg_if #(.DIGITS(D), .BR_W(BR)) cfg ();

  seg_scan_display #(
    .DIGITS(D), .CLK_DIV(CD), .BR_W(BR), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg),
    .SEG(SEG), .AN(AN), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  function automatic logic [7:0] font(input int v);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                           8'h82, 8'hF8, 8'h80, 8'h98, 8'h88, 8'h83,
                           8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  // a load seen at edge m goes live at the first frame-wrap edge after m
  function automatic int golive(input int m);
    return (m / FR + 1) * FR;
  endfunction

  // expected {frame_done, load_pending, SEG, AN} just after edge n
  function automatic logic [17:0] model(input int n);
    cfg_t       c;
    int         t, cnt, pos, frame, nibv;
    logic       lp, fd, blank;
    logic [7:0] seg;
    logic [7:0] an;
    c     = '{m: 0, d: 0, dp: 0, bm: 0, lz: 0, br: 0};
    lp    = 1'b0;
    foreach (log_q[k]) begin
      if (golive(log_q[k].m) < n) c = log_q[k];
    end
    if (log_q.size() > 0) lp = golive(log_q[log_q.size()-1].m) > n;
    fd    = (n >= FR) && (n % FR == 0);
    t     = n - 1;
    cnt   = t % CD;
    pos   = (t / CD) % D;
    frame = t / FR;
    nibv  = int'((c.d >> (4 * pos)) & 32'hF);
    blank = 1'b0;
    if (c.lz && pos != 0 && (c.d >> (4 * pos)) == 0) blank = 1'b1;
    if (c.bm[pos] && ((frame / BF) % 2 == 1)) blank = 1'b1;
    if (!(c.br == 2'd3 || cnt < int'(c.br) * (CD >> BR))) blank = 1'b1;
    seg = 8'hFF;
    an  = 8'hFF;
    if (!blank) begin
      seg      = font(nibv);
      seg[7]   = ~c.dp[pos];
      an[pos]  = 1'b0;
    end
    return {fd, lp, seg, an};
  endfunction

  task automatic do_load(input cfg_t c);
    cfg_t r;
    @(negedge clk);
    cfg.data_in    = c.d;
    cfg.dp_in      = c.dp;
    cfg.blink_mask = c.bm;
    cfg.lz_en      = c.lz;
    cfg.brightness = c.br;
    cfg.load       = 1'b1;
    r   = c;
    r.m = ecnt + 1;
    log_q.push_back(r);
    @(negedge clk);
    cfg.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    cfg.load       = 1'b0;
    cfg.data_in    = '0;
    cfg.dp_in      = '0;
    cfg.blink_mask = '0;
    cfg.lz_en      = 1'b0;
    cfg.brightness = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({frame_done, cfg.load_pending, SEG, AN} !== 18'h0FFFF) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h",
               {frame_done, cfg.load_pending, SEG, AN}, 18'h0FFFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FR + 8) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL reset_idle n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
  endtask

  task automatic test_scan();
    int pulses;
    pulses = 0;
    do_load('{m: 0, d: 32'h12345678, dp: 0, bm: 0, lz: 0, br: 3});
    repeat (3 * FR) begin
      @(posedge clk); #1;
      pulses += int'(frame_done);
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL scan n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
    checks++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL frame_done_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_lz();
    do_load('{m: 0, d: 32'h000000A0, dp: 0, bm: 0, lz: 1, br: 3});
    repeat (2 * FR) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL lz_a0 n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
    do_load('{m: 0, d: 32'h0, dp: 0, bm: 0, lz: 1, br: 3});
    repeat (2 * FR) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL lz_zero n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
  endtask

  task automatic test_midframe();
    // next edge lands in slot 3
    for (int k = 0; k < 2 * FR; k++) begin
      @(negedge clk);
      if ((ecnt % FR) / CD == 3) break;
    end
    do_load('{m: 0, d: 32'hAAAAAAAA, dp: 0, bm: 0, lz: 0, br: 3});
    #1;
    checks++;
    if (cfg.load_pending !== 1'b1) begin
      fails++;
      $display("FAIL midframe_pending got=%b exp=1", cfg.load_pending);
    end
    repeat (2 * FR) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL midframe n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
    // next edge is the wrap tick
    for (int k = 0; k < 2 * FR; k++) begin
      if (ecnt % FR == FR - 2) break;
      @(negedge clk);
    end
    do_load('{m: 0, d: 32'h9ABCDEF0, dp: 8'h81, bm: 0, lz: 0, br: 3});
    repeat (2 * FR + 4) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL wrap_load n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
  endtask

  task automatic test_brightness();
    logic [1:0] lv [3] = '{2'd1, 2'd0, 2'd3};
    foreach (lv[j]) begin
      do_load('{m: 0, d: 32'hFEDCBA98, dp: 8'h55, bm: 0, lz: 0, br: lv[j]});
      repeat (FR + FR / 2) begin
        @(posedge clk); #1;
        exp_v = model(ecnt);
        got_v = {frame_done, cfg.load_pending, SEG, AN};
        checks++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL bright%0d n=%0d got=%h exp=%h",
                   lv[j], ecnt, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_blink();
    do_load('{m: 0, d: 32'h87654321, dp: 8'h02, bm: 8'h01, lz: 0, br: 3});
    repeat (6 * FR) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL blink n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    cfg_t c;
    for (int j = 0; j < 8; j++) begin
      c.m  = 0;
      c.d  = $urandom >> $urandom_range(0, 31);
      c.dp = 8'($urandom_range(0, 255));
      c.bm = 8'($urandom_range(0, 255));
      c.lz = 1'($urandom_range(0, 1));
      c.br = 2'($urandom_range(0, 3));
      do_load(c);
      repeat ($urandom_range(20, 2 * FR)) begin
        @(posedge clk); #1;
        exp_v = model(ecnt);
        got_v = {frame_done, cfg.load_pending, SEG, AN};
        checks++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL random%0d n=%0d got=%h exp=%h", j, ecnt, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_load('{m: 0, d: 32'h13572468, dp: 0, bm: 0, lz: 0, br: 3});
    repeat (FR + 2 * CD + 5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_done, cfg.load_pending, SEG, AN} !== 18'h0FFFF) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h",
               {frame_done, cfg.load_pending, SEG, AN}, 18'h0FFFF);
    end
    log_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FR / 2) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL post_reset n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
    do_load('{m: 0, d: 32'h0000C0DE, dp: 8'h04, bm: 0, lz: 1, br: 3});
    repeat (2 * FR) begin
      @(posedge clk); #1;
      exp_v = model(ecnt);
      got_v = {frame_done, cfg.load_pending, SEG, AN};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL restart n=%0d got=%h exp=%h", ecnt, got_v, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_scan();
    test_lz();
    test_midframe();
    test_brightness();
    test_blink();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
